multicycle_controller: RTL

Multi-cycle sequencing FSM for the 32-bit non-pipelined processor. Fetches each instruction over a request/acknowledge handshake, latches it, decodes its opcode, and steps the datapath through EXEC, MEM and WB. It drives the PC-update, register-write, ALU-select and data-memory strobes that the datapath muxes consume. It counts retired instructions and halts on an unsupported opcode.

---
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the 32-bit non-pipelined processor.
// Fetch/decode/exec/mem/wb control with retire counting and an illegal-opcode halt.
module multicycle_controller #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               instr_req,
  input  logic               instr_ack,
  input  logic [INSTR_W-1:0] instr_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               alu_zero,
  output logic [1:0]         alu_op,
  output logic               alu_src,
  output logic               data_req,
  output logic               data_we,
  input  logic               data_ack,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               retire,
  output logic [CNT_W-1:0]   retire_count,
  output logic               illegal,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_t     st, st_nx;
  logic [5:0] opcode;
  logic       ld_ir, set_ill;
  logic       instr_req_c, alu_src_c, data_req_c, data_we_c;
  logic       reg_write_c, wb_sel_c, pc_write_c, retire_c;
  logic [1:0] alu_op_c, pc_src_c;

  assign opcode = ir[31:26];
  assign state  = st;

  always_comb begin
    st_nx       = st;
    ld_ir       = 1'b0;
    set_ill     = 1'b0;
    instr_req_c = 1'b0;
    alu_op_c    = 2'b00;
    alu_src_c   = 1'b0;
    data_req_c  = 1'b0;
    data_we_c   = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'b00;
    retire_c    = 1'b0;
    case (st)
      FETCH: begin
        instr_req_c = 1'b1;
        if (instr_ack) begin
          ld_ir = 1'b1;
          st_nx = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: st_nx = EXEC;
          default: begin
            set_ill = 1'b1;
            st_nx   = HALT;
          end
        endcase
      end
      EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op_c = 2'b10;
            st_nx    = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            st_nx     = MEM;
          end
          OP_BEQ: begin
            alu_op_c   = 2'b01;
            pc_write_c = 1'b1;
            pc_src_c   = alu_zero ? 2'b01 : 2'b00;
            retire_c   = 1'b1;
            st_nx      = FETCH;
          end
          OP_J: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'b10;
            retire_c   = 1'b1;
            st_nx      = FETCH;
          end
          default: st_nx = HALT;
        endcase
      end
      MEM: begin
        // Address operands stay selected so the memory sees a stable address.
        data_req_c = 1'b1;
        data_we_c  = (opcode == OP_SW);
        alu_src_c  = 1'b1;
        if (data_ack) begin
          if (opcode == OP_SW) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            st_nx      = FETCH;
          end else begin
            st_nx = WB;
          end
        end
      end
      WB: begin
        reg_write_c = 1'b1;
        wb_sel_c    = (opcode == OP_LW);
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        st_nx       = FETCH;
      end
      HALT: st_nx = HALT;
      default: st_nx = FETCH;
    endcase
  end

  // Reset forces every strobe low, including the FETCH request.
  assign instr_req = instr_req_c & ~rst;
  assign alu_op    = rst ? 2'b00 : alu_op_c;
  assign alu_src   = alu_src_c & ~rst;
  assign data_req  = data_req_c & ~rst;
  assign data_we   = data_we_c & ~rst;
  assign reg_write = reg_write_c & ~rst;
  assign wb_sel    = wb_sel_c & ~rst;
  assign pc_write  = pc_write_c & ~rst;
  assign pc_src    = rst ? 2'b00 : pc_src_c;
  assign retire    = retire_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= FETCH;
      ir           <= '0;
      retire_count <= '0;
      illegal      <= 1'b0;
    end else begin
      st <= st_nx;
      if (ld_ir)    ir           <= instr_rdata;
      if (retire_c) retire_count <= retire_count + CNT_W'(1);
      if (set_ill)  illegal      <= 1'b1;
    end
  end

endmodule
